// File: rtl/snn_pkg.sv
// Shared constants for the two-stage LIF spiking core: widths, config
// register addresses, reset defaults and a small sizing helper.
package snn_pkg;

  // Membrane / input / threshold width.
  localparam int DATA_W = 8;

  // Config register select values on cfg_addr.
  localparam logic [1:0] CFG_THRESH = 2'd0;
  localparam logic [1:0] CFG_LEAK   = 2'd1;
  localparam logic [1:0] CFG_WEIGHT = 2'd2;
  localparam logic [1:0] CFG_PERIOD = 2'd3;

  // Values the config registers take on reset.
  localparam int THRESH_DEFAULT = 64;
  localparam int LEAK_DEFAULT   = 3;
  localparam int WEIGHT_DEFAULT = 32;
  localparam int PERIOD_DEFAULT = 0;

  // Bits needed for a refractory down-counter that starts at 'steps'.
  // Never returns 0 so the counter stays a legal vector when refractory is off.
  function automatic int refrac_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire membrane: shift-based leak, signed input,
// saturation to [0, 2^DATA_W-1], threshold with subtract reset and a
// refractory window. State only moves on a timestep tick.
module lif_neuron #(
  parameter int DATA_W       = snn_pkg::DATA_W,
  parameter int REFRAC_STEPS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] thresh,
  input  logic [2:0]        leak_shift,
  input  logic [DATA_W+1:0] inp,
  output logic [DATA_W-1:0] state,
  output logic              spike
);
  import snn_pkg::*;

  // Two guard bits: one for overflow above the saturation ceiling, one sign.
  localparam int ACC_W = DATA_W + 2;
  localparam int RW    = refrac_width(REFRAC_STEPS);

  logic [DATA_W-1:0] u_q;
  logic              spike_q;
  logic [RW-1:0]     refrac_q;

  logic [ACC_W-1:0]  u_ext;
  logic [ACC_W-1:0]  leaked;
  logic [ACC_W-1:0]  inp_eff;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] sum_sat;
  logic              fire;

  // Next-membrane arithmetic in two's complement: leak, gated input, clamp, fire.
  always_comb begin
    u_ext   = {2'b00, u_q};
    leaked  = u_ext;
    if (leak_shift != 3'd0) begin
      leaked = u_ext - (u_ext >> leak_shift);
    end
    inp_eff = (refrac_q != '0) ? '0 : inp;
    sum     = leaked + inp_eff;
    if (sum[ACC_W-1]) begin
      sum_sat = '0;
    end else if (sum[DATA_W]) begin
      sum_sat = '1;
    end else begin
      sum_sat = sum[DATA_W-1:0];
    end
    // A refractory neuron never fires, even with thresh=0.
    fire = (refrac_q == '0) && (sum_sat >= thresh);
  end

  // Commit membrane, spike flag and refractory counter on each timestep.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_q      <= '0;
      spike_q  <= 1'b0;
      refrac_q <= '0;
    end else if (tick) begin
      spike_q <= fire;
      if (fire) begin
        u_q      <= sum_sat - thresh;
        refrac_q <= RW'(REFRAC_STEPS);
      end else begin
        u_q <= sum_sat;
        if (refrac_q != '0) begin
          refrac_q <= refrac_q - 1'b1;
        end
      end
    end
  end

  assign state = u_q;
  assign spike = spike_q;

endmodule

// File: rtl/lif_neuron_pair.sv
// Two-stage LIF core: neuron 1 integrates in1, neuron 2 integrates neuron 1's
// spikes through a signed weight with one timestep of synaptic delay.
// Holds the runtime config registers, the timestep prescaler and the
// config write handshake.
module lif_neuron_pair #(
  parameter int DATA_W       = snn_pkg::DATA_W,
  parameter int PERIOD_W     = 16,
  parameter int REFRAC_STEPS = 2
) (
  input  logic              wb_clk_i,
  input  logic              reset,
  input  logic              active,
  input  logic [DATA_W-1:0] in1,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              cfg_ready,
  output logic              step_tick,
  output logic [1:0]        spike_out,
  output logic [DATA_W-1:0] state1,
  output logic [DATA_W-1:0] state2
);
  import snn_pkg::*;

  localparam int ACC_W = DATA_W + 2;

  logic [DATA_W-1:0]   thresh_q;
  logic [2:0]          leak_q;
  logic [7:0]          weight_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;

  logic                tick;
  logic [ACC_W-1:0]    inp1;
  logic [ACC_W-1:0]    inp2;
  logic                spike1;
  logic                spike2;

  // Handshake: a config write transfers on any cycle where cfg_valid and
  // cfg_ready are both high. cfg_ready drops only in the tick cycle so the
  // neurons never see a config change on the edge they update; a source that
  // finds cfg_ready low keeps cfg_valid, addr and data stable and the write
  // lands on the following cycle.
  //
  // The >= compare only matters after period is lowered below the running
  // count; it makes the prescaler wrap at once instead of counting through
  // the whole counter range.
  assign tick      = active && !reset && (cnt_q >= period_q);
  assign step_tick = tick;
  assign cfg_ready = !tick;

  // Prescaler: count 0..period while active, held at 0 while inactive.
  always_ff @(posedge wb_clk_i) begin
    if (reset || !active) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Config registers: reset to defaults, written on an accepted handshake.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      thresh_q <= DATA_W'(THRESH_DEFAULT);
      leak_q   <= 3'(LEAK_DEFAULT);
      weight_q <= 8'(WEIGHT_DEFAULT);
      period_q <= PERIOD_W'(PERIOD_DEFAULT);
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        CFG_THRESH: thresh_q <= DATA_W'(cfg_data[7:0]);
        CFG_LEAK:   leak_q   <= cfg_data[2:0];
        CFG_WEIGHT: weight_q <= cfg_data[7:0];
        CFG_PERIOD: period_q <= PERIOD_W'(cfg_data);
        default: ;
      endcase
    end
  end

  // Neuron 1 sees the unsigned input current; neuron 2 sees the sign-extended
  // weight when neuron 1's registered spike (last timestep's) is set.
  always_comb begin
    inp1 = {2'b00, in1};
    inp2 = '0;
    if (spike1) begin
      inp2 = {{(ACC_W-8){weight_q[7]}}, weight_q};
    end
  end

  lif_neuron #(
    .DATA_W       (DATA_W),
    .REFRAC_STEPS (REFRAC_STEPS)
  ) u_neuron1 (
    .clk        (wb_clk_i),
    .reset      (reset),
    .tick       (tick),
    .thresh     (thresh_q),
    .leak_shift (leak_q),
    .inp        (inp1),
    .state      (state1),
    .spike      (spike1)
  );

  lif_neuron #(
    .DATA_W       (DATA_W),
    .REFRAC_STEPS (REFRAC_STEPS)
  ) u_neuron2 (
    .clk        (wb_clk_i),
    .reset      (reset),
    .tick       (tick),
    .thresh     (thresh_q),
    .leak_shift (leak_q),
    .inp        (inp2),
    .state      (state2),
    .spike      (spike2)
  );

  assign spike_out = {spike2, spike1};

endmodule

// File: tb/tb_lif_neuron_pair.sv
// Directed bench for lif_neuron_pair: neuron sequences with hand-derived
// membrane values, prescaler/handshake timing and config reset defaults.
module tb_lif_neuron_pair;
  import snn_pkg::*;

  logic        wb_clk_i  = 1'b0;
  logic        reset     = 1'b1;
  logic        active    = 1'b0;
  logic [7:0]  in1       = '0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_addr  = '0;
  logic [15:0] cfg_data  = '0;
  logic        cfg_ready;
  logic        step_tick;
  logic [1:0]  spike_out;
  logic [7:0]  state1;
  logic [7:0]  state2;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {spike_out, state2, state1} per timestep, in tick order.
  logic [17:0] exp_q[$];

  lif_neuron_pair #(
    .DATA_W       (8),
    .PERIOD_W     (16),
    .REFRAC_STEPS (2)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .active    (active),
    .in1       (in1),
    .cfg_valid (cfg_valid),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .step_tick (step_tick),
    .spike_out (spike_out),
    .state1    (state1),
    .state2    (state2)
  );

  // Clock
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [17:0] pk(input logic [7:0] s1, input logic [7:0] s2,
                                     input logic [1:0] sp);
    return {sp, s2, s1};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset for two cycles; returns at a falling edge with reset released.
  task automatic do_reset();
    @(negedge wb_clk_i);
    reset     = 1'b1;
    active    = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    reset = 1'b0;
  endtask

  // Config write while inactive (cfg_ready is high); starts and ends at a falling edge.
  task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    @(negedge wb_clk_i);
    cfg_valid = 1'b0;
  endtask

  // Push the expectation, enable the prescaler until one tick fires, then
  // drop active and compare the post-tick outputs against the popped entry.
  task automatic run_tick(input string tag, input logic [17:0] exp);
    int n;
    exp_q.push_back(exp);
    active = 1'b1;
    #1;
    n = 0;
    while (!step_tick && n < 32) begin
      @(negedge wb_clk_i);
      #1;
      n++;
    end
    if (!step_tick) begin
      check({tag, "_tick_timeout"}, {17'b0, step_tick}, 18'd1);
      void'(exp_q.pop_front());
      @(negedge wb_clk_i);
      active = 1'b0;
    end else begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      active = 1'b0;
      check(tag, {spike_out, state2, state1}, exp_q.pop_front());
    end
  endtask

  logic [7:0] leak_exp [9] = '{8'd100, 8'd50, 8'd25, 8'd13, 8'd7, 8'd4, 8'd2, 8'd1, 8'd1};
  logic [1:0] psc_exp  [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_outputs", {spike_out, state2, state1}, pk(8'd0, 8'd0, 2'b00));
    check("rst_ready_tick", {16'b0, cfg_ready, step_tick}, 18'b10);
    @(negedge wb_clk_i);

    // Integration, refractory, freeze and weight=40 propagation
    cfg_write(CFG_LEAK, 16'd0);
    cfg_write(CFG_WEIGHT, 16'd40);
    in1 = 8'd20;
    run_tick("a_t1", pk(8'd20, 8'd0, 2'b00));
    run_tick("a_t2", pk(8'd40, 8'd0, 2'b00));
    run_tick("a_t3", pk(8'd60, 8'd0, 2'b00));
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      #1;
      check($sformatf("a_freeze%0d", i), {spike_out, state2, state1}, pk(8'd60, 8'd0, 2'b00));
      check($sformatf("a_freeze_tick%0d", i), {17'b0, step_tick}, 18'd0);
    end
    @(negedge wb_clk_i);
    run_tick("a_t4",  pk(8'd16, 8'd0,  2'b01));
    run_tick("a_t5",  pk(8'd16, 8'd40, 2'b00));
    run_tick("a_t6",  pk(8'd16, 8'd40, 2'b00));
    run_tick("a_t7",  pk(8'd36, 8'd40, 2'b00));
    run_tick("a_t8",  pk(8'd56, 8'd40, 2'b00));
    run_tick("a_t9",  pk(8'd12, 8'd40, 2'b01));
    run_tick("a_t10", pk(8'd12, 8'd16, 2'b10));
    run_tick("a_t11", pk(8'd12, 8'd16, 2'b00));
    run_tick("a_t12", pk(8'd32, 8'd16, 2'b00));
    run_tick("a_t13", pk(8'd52, 8'd16, 2'b00));

    // Leak with shift 1, single input pulse, no spike
    do_reset();
    cfg_write(CFG_LEAK, 16'd1);
    cfg_write(CFG_THRESH, 16'd200);
    in1 = 8'd100;
    for (int i = 0; i < 9; i++) begin
      run_tick($sformatf("leak_t%0d", i + 1), pk(leak_exp[i], 8'd0, 2'b00));
      in1 = 8'd0;
    end

    // Saturation at 255 with thresh 255, then refractory steps
    do_reset();
    cfg_write(CFG_LEAK, 16'd0);
    cfg_write(CFG_THRESH, 16'd255);
    in1 = 8'd255;
    run_tick("sat_t1", pk(8'd0, 8'd0,  2'b01));
    run_tick("sat_t2", pk(8'd0, 8'd32, 2'b00));
    run_tick("sat_t3", pk(8'd0, 8'd32, 2'b00));
    run_tick("sat_t4", pk(8'd0, 8'd32, 2'b01));

    // Negative weight keeps neuron 2 clamped at 0
    do_reset();
    cfg_write(CFG_LEAK, 16'd0);
    cfg_write(CFG_WEIGHT, 16'h00F0);
    in1 = 8'd20;
    run_tick("neg_t1", pk(8'd20, 8'd0, 2'b00));
    run_tick("neg_t2", pk(8'd40, 8'd0, 2'b00));
    run_tick("neg_t3", pk(8'd60, 8'd0, 2'b00));
    run_tick("neg_t4", pk(8'd16, 8'd0, 2'b01));
    run_tick("neg_t5", pk(8'd16, 8'd0, 2'b00));
    run_tick("neg_t6", pk(8'd16, 8'd0, 2'b00));

    // Prescaler period 3: tick every 4 cycles, cfg_ready low exactly then
    do_reset();
    in1 = 8'd0;
    cfg_write(CFG_PERIOD, 16'd3);
    active = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("psc_c%0d", k), {16'b0, step_tick, cfg_ready},
            (k % 4 == 3) ? 18'b10 : 18'b01);
      @(negedge wb_clk_i);
    end
    repeat (2) @(negedge wb_clk_i);
    // Inactive mid-count: no ticks, counter returns to 0
    active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("psc_idle%0d", k), {16'b0, step_tick, cfg_ready}, 18'b01);
      @(negedge wb_clk_i);
    end
    // Resume; a period write raised on the tick cycle lands one cycle later
    active = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_PERIOD;
        cfg_data  = 16'd1;
      end
      if (k == 5) cfg_valid = 1'b0;
      #1;
      check($sformatf("psc_resume%0d", k), {16'b0, step_tick, cfg_ready}, {16'b0, psc_exp[k]});
      @(negedge wb_clk_i);
    end
    active = 1'b0;
    @(negedge wb_clk_i);

    // Overwrite every register, then reset must restore all defaults
    cfg_write(CFG_THRESH, 16'd10);
    cfg_write(CFG_LEAK, 16'd0);
    cfg_write(CFG_WEIGHT, 16'd1);
    cfg_write(CFG_PERIOD, 16'd5);
    in1 = 8'd20;
    run_tick("mid_t1", pk(8'd10, 8'd0, 2'b01));
    do_reset();
    active = 1'b1;
    #1;
    check("dflt_period_tick", {17'b0, step_tick}, 18'd1);
    run_tick("dflt_t1", pk(8'd20, 8'd0,  2'b00));
    run_tick("dflt_t2", pk(8'd38, 8'd0,  2'b00));
    run_tick("dflt_t3", pk(8'd54, 8'd0,  2'b00));
    run_tick("dflt_t4", pk(8'd4,  8'd0,  2'b01));
    run_tick("dflt_t5", pk(8'd4,  8'd32, 2'b00));

    check("scoreboard_drained", 18'(exp_q.size()), 18'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
